// File: rtl/logic_pipe_pkg.sv
// ============================================================================
// logic_pipe_pkg : op encodings and the per-stage bitwise function
// Rev 1.0
// ============================================================================
`default_nettype none

package logic_pipe_pkg;

  typedef enum logic [1:0] {
    OP_PASS = 2'd0,
    OP_INV  = 2'd1,
    OP_NAND = 2'd2,
    OP_NOR  = 2'd3
  } op_e;

  // Widest word the shared function handles; callers zero-extend and truncate.
  localparam int c_MAX_W = 64;

  function automatic logic [c_MAX_W-1:0] stage_f(op_e op, logic [c_MAX_W-1:0] x, int width);
    logic [c_MAX_W-1:0] w_mask;
    logic [c_MAX_W-1:0] w_x;
    logic [c_MAX_W-1:0] w_r;
    w_mask = (width >= c_MAX_W) ? '1 : ((c_MAX_W'(1) << width) - c_MAX_W'(1));
    w_x    = x & w_mask;
    w_r    = ((w_x << 1) | (w_x >> (width - 1))) & w_mask;
    stage_f = w_x;
    case (op)
      OP_INV:  stage_f = ~w_x & w_mask;
      OP_NAND: stage_f = ~(w_x & w_r) & w_mask;
      OP_NOR:  stage_f = ~(w_x | w_r) & w_mask;
      default: stage_f = w_x;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/logic_pipe_if.sv
// ============================================================================
// logic_pipe_if : valid/ready input and output channels of logic_pipe
// Rev 1.0
// ============================================================================
`default_nettype none

interface logic_pipe_if
  import logic_pipe_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  op_e              in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  op_e              out_op;

  modport slave (
    input  in_valid, in_data, in_op, out_ready,
    output in_ready, out_valid, out_data, out_op
  );

  modport master (
    output in_valid, in_data, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_op
  );
endinterface

`default_nettype wire

// File: rtl/logic_pipe_stage.sv
// ============================================================================
// logic_pipe_stage : one elastic valid/data/op register applying stage_f
// Rev 1.0
// ============================================================================
`default_nettype none

module logic_pipe_stage
  import logic_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_flush,
  input  wire logic             i_up_valid,
  input  wire logic [WIDTH-1:0] i_up_data,
  input  wire op_e              i_up_op,
  input  wire logic             i_dn_ready,
  output logic                  o_valid,
  output logic                  o_ready,
  output logic [WIDTH-1:0]      o_data,
  output op_e                   o_op
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  op_e              r_op;
  logic [WIDTH-1:0] w_f;
  logic             w_load;

  assign o_ready = ~r_valid | i_dn_ready;
  // Flush blocks capture so the data registers keep their old contents.
  assign w_load  = i_up_valid & o_ready & ~i_flush;
  assign w_f     = WIDTH'(stage_f(i_up_op, c_MAX_W'(i_up_data), WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_op    <= OP_PASS;
    end else begin
      if (i_flush) begin
        r_valid <= 1'b0;
      end else if (o_ready) begin
        r_valid <= i_up_valid;
      end
      if (w_load) begin
        r_data <= w_f;
        r_op   <= i_up_op;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_op    = r_op;

endmodule

`default_nettype wire

// File: rtl/logic_pipe.sv
// ============================================================================
// logic_pipe : STAGES-deep elastic pipeline of selectable bitwise stages
// Rev 1.0
// ============================================================================
`default_nettype none

module logic_pipe
  import logic_pipe_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int STAGES = 2,
  localparam int OCC_W  = $clog2(STAGES + 1)
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        flush,
  logic_pipe_if.slave      bus,
  output logic [OCC_W-1:0] occupancy
);

  logic [STAGES-1:0]            w_valid;
  logic [STAGES-1:0]            w_up_valid;
  logic [STAGES:0]              w_ready;
  logic [STAGES-1:0][WIDTH-1:0] w_data;
  logic [STAGES-1:0][WIDTH-1:0] w_up_data;
  op_e  [STAGES-1:0]            w_op;
  op_e  [STAGES-1:0]            w_up_op;
  logic                         w_in_hs;
  logic                         w_out_hs;
  logic [OCC_W-1:0]             r_occ;

  assign w_ready[STAGES] = bus.out_ready;

  generate
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
      if (s == 0) begin : g_head
        assign w_up_valid[s] = bus.in_valid;
        assign w_up_data[s]  = bus.in_data;
        assign w_up_op[s]    = bus.in_op;
      end else begin : g_body
        assign w_up_valid[s] = w_valid[s-1];
        assign w_up_data[s]  = w_data[s-1];
        assign w_up_op[s]    = w_op[s-1];
      end

      logic_pipe_stage #(
        .WIDTH (WIDTH)
      ) u_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (flush),
        .i_up_valid (w_up_valid[s]),
        .i_up_data  (w_up_data[s]),
        .i_up_op    (w_up_op[s]),
        .i_dn_ready (w_ready[s+1]),
        .o_valid    (w_valid[s]),
        .o_ready    (w_ready[s]),
        .o_data     (w_data[s]),
        .o_op       (w_op[s])
      );
    end
  endgenerate

  assign bus.in_ready  = w_ready[0] & ~flush;
  assign bus.out_valid = w_valid[STAGES-1];
  assign bus.out_data  = w_data[STAGES-1];
  assign bus.out_op    = w_op[STAGES-1];

  // Internal stage-to-stage moves never change the count; only the two ends do.
  assign w_in_hs  = bus.in_valid & bus.in_ready;
  assign w_out_hs = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else begin
      r_occ <= r_occ + OCC_W'(w_in_hs) - OCC_W'(w_out_hs);
    end
  end

  assign occupancy = r_occ;

endmodule

`default_nettype wire

// File: tb/tb_logic_pipe.sv
// ============================================================================
// tb_logic_pipe : scoreboard bench for logic_pipe (WIDTH=8, STAGES=2)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_logic_pipe;
  import logic_pipe_pkg::*;

  typedef struct {
    logic [7:0] data;
    logic [1:0] op;
  } sb_t;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [1:0] occ;
  int         n_checks;
  int         n_pass;
  int         n_out;
  sb_t        q[$];
  sb_t        e_mon;

  logic_pipe_if #(.WIDTH(8)) bus ();

  logic_pipe #(
    .WIDTH  (8),
    .STAGES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    else n_pass++;
  endtask

  function automatic logic [7:0] f1(input logic [1:0] op, input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[(i + 7) % 8];
    case (op)
      2'd0:    return x;
      2'd1:    return ~x;
      2'd2:    return ~(x & r);
      default: return ~(x | r);
    endcase
  endfunction

  function automatic logic [7:0] model(input logic [7:0] d, input logic [1:0] op);
    return f1(op, f1(op, d));
  endfunction

  // Output side is compared before any flush/reset discards the rest.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          check("spurious_out", 32'(bus.out_valid), 32'd0);
        end else begin
          e_mon = q.pop_front();
          check("sb_data", 32'(bus.out_data), 32'(e_mon.data));
          check("sb_op", 32'(bus.out_op), 32'(e_mon.op));
        end
        n_out++;
      end
      if (flush) q.delete();
      if (bus.in_valid && bus.in_ready)
        q.push_back('{model(bus.in_data, bus.in_op), bus.in_op});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic single(input logic [7:0] d, input op_e op, input logic [7:0] exp, input string tag);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_op     = op;
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check({tag, "_early"}, 32'(bus.out_valid), 32'd0);
    step();
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_data"}, 32'(bus.out_data), 32'(exp));
    check({tag, "_op"}, 32'(bus.out_op), 32'(op));
    step();
    check({tag, "_pulse"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int         n0;
    int         stalls;
    logic [7:0] w0_exp;

    n_checks      = 0;
    n_pass        = 0;
    n_out         = 0;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_op     = OP_PASS;
    bus.out_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'h00);
    check("rst_occ", 32'(occ), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    single(8'hA5, OP_INV, 8'hA5, "inv_a5");
    single(8'h0F, OP_NAND, 8'h1E, "nand_0f");
    single(8'h00, OP_NOR, 8'h00, "nor_00");

    // Back-to-back stream of 16 random words.
    bus.out_ready = 1'b1;
    n0     = n_out;
    stalls = 0;
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      bus.in_op    = op_e'($urandom_range(0, 3));
      if (!bus.in_ready) stalls++;
      step();
    end
    bus.in_valid = 1'b0;
    repeat (2) step();
    check("stream_count", 32'(n_out - n0), 32'd16);
    check("stream_stalls", 32'(stalls), 32'd0);

    // Backpressure: third word must wait until downstream releases.
    bus.out_ready = 1'b0;
    n0            = n_out;
    w0_exp        = model(8'h3C, 2'd2);
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h3C;
    bus.in_op     = OP_NAND;
    step();
    bus.in_data = 8'hC3;
    bus.in_op   = OP_NOR;
    step();
    bus.in_data = 8'h5A;
    bus.in_op   = OP_INV;
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    check("full_occ", 32'(occ), 32'd2);
    check("full_out_valid", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_data", 32'(bus.out_data), 32'(w0_exp));
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_occ", 32'(occ), 32'd2);
    end
    bus.out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check("simul_occ", 32'(occ), 32'd2);
    repeat (3) step();
    check("bp_count", 32'(n_out - n0), 32'd3);
    check("bp_drain_occ", 32'(occ), 32'd0);

    // Flush with two words in flight and a word offered at the input.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h11;
    bus.in_op     = OP_PASS;
    step();
    bus.in_data = 8'h22;
    step();
    check("pre_flush_occ", 32'(occ), 32'd2);
    bus.out_ready = 1'b1;
    bus.in_data   = 8'h33;
    flush         = 1'b1;
    #1;
    check("flush_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    n0           = n_out;
    check("flush_occ", 32'(occ), 32'd0);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    repeat (3) step();
    check("flush_no_out", 32'(n_out - n0), 32'd0);
    check("flush_occ_after", 32'(occ), 32'd0);

    // Asynchronous reset between edges with a stream in flight.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 8'h40 + 8'(i);
      bus.in_op   = OP_INV;
      step();
    end
    #2;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_occ", 32'(occ), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    rst_n = 1'b1;
    n0    = n_out;
    repeat (2) step();
    check("arst_no_out", 32'(n_out - n0), 32'd0);
    single(8'h81, OP_NOR, model(8'h81, 2'd3), "post_rst");

    repeat (2) step();
    check("sb_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/logic_pipe.md
# logic_pipe

Parametrised, elastic, registered logic pipeline: the next generation of the single-bit flop → gate cloud → flop path, generalised to WIDTH-bit data, STAGES register stages and a per-transaction logic mode. Each stage applies a selectable bitwise function to the word and registers the result. Valid/ready backpressure, synchronous flush and an occupancy count make it usable as a real datapath segment and as a parametrised STA/timing-closure vehicle.

## Interface
- WIDTH, 8, data width in bits (≥2)
- STAGES, 2, number of register stages = latency (≥1)
- OCC_W, $clog2(STAGES+1), occupancy counter width (derived, not overridden)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset; all state clears immediately
- flush  in  1  synchronous clear of all stage valids
- in_valid  in  1  upstream word valid
- in_ready  out  1  pipeline accepts word this cycle
- in_data  in  WIDTH  input word
- in_op  in  2  logic mode for this word, travels with it
- out_valid  out  1  last stage holds a word
- out_ready  in  1  downstream accepts word
- out_data  out  WIDTH  result after STAGES applications of f
- out_op  out  2  mode that produced out_data
- occupancy  out  OCC_W  number of stages currently valid

## Operation
- Stage function f(op,x), r = x rotated left by 1: op 0 PASS → x; op 1 INV → ~x; op 2 NAND → ~(x & r); op 3 NOR → ~(x | r).
- Stage 0 captures {f(in_op,in_data), in_op} on an input handshake (in_valid & in_ready).
- Stage s>0 captures {f(op[s-1],data[s-1]), op[s-1]} when stage s-1 is valid and stage s is ready.
- ready[s] = ~valid[s] | ready[s+1]; ready[STAGES] = out_ready. in_ready = ready[0] & ~flush. Combinational ready chain; no bubbles when out_ready held high.
- Stage valid sets on capture, clears when its word moves on and no new word arrives.
- A word held in a stage is stable (data, op, valid) until it moves on.
- out_valid/out_data/out_op are the last stage's registers directly; no combinational path from inputs to them.
- occupancy = popcount of stage valids, registered, updated the same edge as the valids.
- flush: next edge clears every valid and occupancy to 0; any input handshake that cycle is blocked (in_ready low); out handshake in the same cycle still counts as consumed downstream, and the word is dropped regardless. Data registers keep their value.
- Reset: all valids, data, op and occupancy go to 0 asynchronously; in_ready = 1 after reset if flush low.

## Timing
- Latency: handshake at edge t → out_valid high after edge t+STAGES-1 (word visible for the cycle following), i.e. STAGES cycles, with no backpressure.
- Throughput: one word per cycle with out_ready high.
- Full: all STAGES valid and out_ready low → in_ready low same cycle (combinational).
- Simultaneous in and out handshake when full: accepted; occupancy unchanged.
- Empty: out_valid low, occupancy 0, in_ready high.
- Reset mid-transfer: in-flight words lost; no output handshake until new input.

## Structure
- Package logic_pipe_pkg: op_e enum (OP_PASS=0, OP_INV=1, OP_NAND=2, OP_NOR=3) and function stage_f(op, x) parametrised by width.
- Sub-module logic_pipe_stage: one valid/data/op register with its ready logic and stage_f; top instantiates STAGES of them in a generate loop plus occupancy counter and flush gating.

## Test plan
- WIDTH=8, STAGES=2, reset then idle → out_valid 0, out_data 0x00, occupancy 0, in_ready 1.
- Single word 0xA5 op INV, out_ready=1 → out_data 0xA5, out_op 1, out_valid exactly 2 cycles after handshake; single-cycle pulse.
- 0x0F op NAND → 0x1E; 0x00 op NOR → 0x00; back-to-back streams of 16 words give 16 outputs on 16 consecutive cycles, matching a reference model.
- out_ready low, push 3 words → in_ready low after 2 accepted, occupancy 2, out_data held; release → words emerge in order, no loss or duplicate.
- flush with occupancy 2 and in_valid high → next cycle occupancy 0, out_valid 0, input word not accepted.
- rst_n pulsed low mid-stream (asynchronous, between edges) → out_valid and occupancy 0 immediately; new word after release has normal latency.
